// File: rtl/ex_mdu_if.sv
// rtl/ex_mdu_if.sv - issue/result handshake bundle between the EX stage and the multiply/divide unit
interface ex_mdu_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            op;
    logic [XLEN-1:0]       src1;
    logic [XLEN-1:0]       src2;
    logic [REG_ADDR_W-1:0] rd_addr_i;
    logic                  rd_enable_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [XLEN-1:0]       rd_data_o;
    logic [REG_ADDR_W-1:0] rd_addr_o;
    logic                  rd_enable_o;

    modport master (
        output in_valid, op, src1, src2, rd_addr_i, rd_enable_i, out_ready,
        input  in_ready, out_valid, rd_data_o, rd_addr_o, rd_enable_o
    );

    modport slave (
        input  in_valid, op, src1, src2, rd_addr_i, rd_enable_i, out_ready,
        output in_ready, out_valid, rd_data_o, rd_addr_o, rd_enable_o
    );
endinterface

// File: rtl/ex_mdu.sv
// rtl/ex_mdu.sv - iterative RV32M multiply/divide unit, one bit per cycle, sign-magnitude datapath
module ex_mdu #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    output logic       busy,
    ex_mdu_if.slave    mdu
);
    localparam int CNT_W = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    state_t state_q, state_d;

    logic [2:0]            op_q;
    logic                  neg_q;
    logic [XLEN:0]         hi_q;
    logic [XLEN-1:0]       lo_q;
    logic [XLEN-1:0]       opnd_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [XLEN-1:0]       data_q;
    logic [REG_ADDR_W-1:0] addr_q;
    logic                  en_q;

    logic            accept, is_div, s1_signed, s2_signed, neg1, neg2;
    logic            div_zero, div_ovf, special, last_iter;
    logic [XLEN-1:0] mag1, mag2, special_res;

    assign accept    = mdu.in_valid && (state_q == S_IDLE) && !flush;
    assign is_div    = mdu.op[2];
    assign last_iter = (cnt_q == CNT_W'(1));

    always_comb begin
        s1_signed = 1'b0;
        s2_signed = 1'b0;
        case (mdu.op)
            3'b000, 3'b001, 3'b100, 3'b110: begin s1_signed = 1'b1; s2_signed = 1'b1; end
            3'b010:                         s1_signed = 1'b1;
            default:                        ;
        endcase
        neg1        = s1_signed && mdu.src1[XLEN-1];
        neg2        = s2_signed && mdu.src2[XLEN-1];
        mag1        = neg1 ? -mdu.src1 : mdu.src1;
        mag2        = neg2 ? -mdu.src2 : mdu.src2;
        div_zero    = is_div && (mdu.src2 == '0);
        div_ovf     = is_div && !mdu.op[0] && (mdu.src1 == SMIN) && (mdu.src2 == '1);
        special     = div_zero || div_ovf;
        // op[1] distinguishes REM/REMU from DIV/DIVU
        if (div_zero) special_res = mdu.op[1] ? mdu.src1 : '1;
        else          special_res = mdu.op[1] ? '0 : mdu.src1;
    end

    // One iteration of shift-add (multiply) or restoring subtract (divide)
    logic [XLEN:0]     sum, shifted, trial, hi_n;
    logic [XLEN-1:0]   lo_n, qr, calc_res;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        sum      = hi_q + (lo_q[0] ? {1'b0, opnd_q} : '0);
        shifted  = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
        trial    = shifted - {1'b0, opnd_q};
        prod     = '0;
        prod_s   = '0;
        qr       = '0;
        calc_res = '0;
        if (op_q[2]) begin
            if (trial[XLEN]) begin
                hi_n = shifted;
                lo_n = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                hi_n = trial;
                lo_n = {lo_q[XLEN-2:0], 1'b1};
            end
            qr       = op_q[1] ? hi_n[XLEN-1:0] : lo_n;
            calc_res = neg_q ? -qr : qr;
        end else begin
            hi_n     = {1'b0, sum[XLEN:1]};
            lo_n     = {sum[0], lo_q[XLEN-1:1]};
            prod     = {hi_n[XLEN-1:0], lo_n};
            prod_s   = neg_q ? -prod : prod;
            calc_res = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (last_iter) state_d = S_DONE;
            S_DONE:  if (mdu.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            data_q <= '0;
            addr_q <= '0;
            en_q   <= 1'b0;
        end else if (!flush) begin
            if (accept) begin
                op_q   <= mdu.op;
                addr_q <= mdu.rd_addr_i;
                en_q   <= mdu.rd_enable_i;
                // Remainder takes the dividend's sign; everything else takes the product sign
                neg_q  <= (is_div && mdu.op[1]) ? neg1 : (neg1 ^ neg2);
                hi_q   <= '0;
                lo_q   <= is_div ? mag1 : mag2;
                opnd_q <= is_div ? mag2 : mag1;
                cnt_q  <= CNT_W'(XLEN);
                if (special) data_q <= special_res;
            end else if (state_q == S_CALC) begin
                hi_q  <= hi_n;
                lo_q  <= lo_n;
                cnt_q <= cnt_q - CNT_W'(1);
                if (last_iter) data_q <= calc_res;
            end
        end
    end

    assign mdu.in_ready    = (state_q == S_IDLE);
    assign mdu.out_valid   = (state_q == S_DONE);
    assign mdu.rd_data_o   = data_q;
    assign mdu.rd_addr_o   = addr_q;
    assign mdu.rd_enable_o = mdu.out_valid && en_q && (addr_q != '0);
    assign busy            = (state_q != S_IDLE);
endmodule

// File: tb/tb_ex_mdu.sv
// tb/tb_ex_mdu.sv - randomized and directed checks of ex_mdu against an arithmetic reference model
module tb_ex_mdu;
    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam logic [31:0] SMIN = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic busy;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ex_mdu_if #(.XLEN(XLEN), .REG_ADDR_W(RAW)) bus ();

    ex_mdu #(.XLEN(XLEN), .REG_ADDR_W(RAW)) dut (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .busy (busy),
        .mdu  (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        sa = $signed(a);
        sb = $signed(b);
        ub = {32'b0, b};
        up = {32'b0, a} * {32'b0, b};
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == SMIN && b == 32'hFFFF_FFFF) return a;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == SMIN && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return op[2] && ((b == 0) || (!op[0] && a == SMIN && b == 32'hFFFF_FFFF));
    endfunction

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic en);
        bus.op          = op;
        bus.src1        = a;
        bus.src2        = b;
        bus.rd_addr_i   = rd;
        bus.rd_enable_i = en;
        bus.in_valid    = 1'b1;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic [4:0] rd, input logic en,
                          input int hold, input logic junk);
        int          lat;
        int          guard;
        logic [31:0] data_seen;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        check("in_ready_before_issue", bus.in_ready, 1);
        drive(op, a, b, rd, en);
        @(posedge clk); #1;
        if (junk) begin
            bus.op        = 3'($urandom);
            bus.src1      = $urandom;
            bus.src2      = $urandom;
            bus.rd_addr_i = 5'($urandom);
        end else begin
            bus.in_valid = 1'b0;
        end
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        bus.in_valid = 1'b0;
        check("latency", lat, is_special(op, a, b) ? 0 : XLEN);
        check("rd_data", bus.rd_data_o, exp);
        check("rd_addr", bus.rd_addr_o, rd);
        check("rd_enable", bus.rd_enable_o, en && (rd != 0));
        data_seen = bus.rd_data_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_stable", {bus.out_valid, bus.in_ready, bus.rd_data_o, bus.rd_addr_o, bus.rd_enable_o},
                  {1'b1, 1'b0, data_seen, rd, en && (rd != 0)});
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("idle_after_consume", {bus.out_valid, bus.in_ready, busy}, 3'b010);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        drive(op, a, b, rd, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t dir[14] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
        '{3'd5, 32'd100,        32'd7,         32'd14},
        '{3'd7, 32'd100,        32'd7,         32'd2},
        '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
        '{3'd6, 32'd5,          32'd0,         32'd5},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
        '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0},
        '{3'd0, 32'h0001_0000,  32'h0001_0000, 32'd0}
    };

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return SMIN;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        rst             = 1'b1;
        flush           = 1'b0;
        bus.in_valid    = 1'b0;
        bus.op          = '0;
        bus.src1        = '0;
        bus.src2        = '0;
        bus.rd_addr_i   = '0;
        bus.rd_enable_i = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {bus.out_valid, bus.in_ready, busy, bus.rd_data_o, bus.rd_addr_o, bus.rd_enable_o},
              {1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0});
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (dir[i]) run_op(dir[i].op, dir[i].a, dir[i].b, dir[i].exp, 5'(i + 1), 1'b1, 0, 1'b0);

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5'd9, 1'b1, 10, 1'b0);
        run_op(3'd5, 32'd100, 32'd7, 32'd14, 5'd0, 1'b1, 3, 1'b0);
        run_op(3'd7, 32'd100, 32'd7, 32'd2, 5'd4, 1'b0, 0, 1'b1);

        issue(3'd0, 32'd123, 32'd456, 5'd3);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_calc", {bus.out_valid, bus.in_ready, busy, bus.rd_enable_o}, 4'b0100);
        @(posedge clk); #1;
        run_op(3'd0, 32'd123, 32'd456, 32'd56088, 5'd3, 1'b1, 0, 1'b0);

        issue(3'd5, 32'd5, 32'd0, 5'd7);
        check("special_done", {bus.out_valid, bus.rd_enable_o}, 2'b11);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_done", {bus.out_valid, bus.in_ready, bus.rd_enable_o}, 3'b010);

        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd12);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_mid_calc", {bus.out_valid, bus.in_ready, busy, bus.rd_data_o, bus.rd_addr_o, bus.rd_enable_o},
              {1'b0, 1'b1, 1'b0, 32'd0, 5'd0, 1'b0});
        rst = 1'b0;
        @(posedge clk); #1;

        for (int n = 0; n < 40; n++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = pick();
            r_b  = pick();
            run_op(r_op, r_a, r_b, model(r_op, r_a, r_b), 5'($urandom), 1'($urandom),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
Iterative multiply/divide execute unit for the RV32M extension, parametrised in data width.
- Sits beside the combinational ALU in the EX stage and takes the same decoded operands and destination fields.
- Runs multi-cycle with a valid/ready handshake on both sides.
- The pipeline stalls on in_ready low and flushes in-flight work on branch mispredict.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8.
REG_ADDR_W, 5, destination register address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-high.
flush  in  1  synchronous kill of any in-flight or pending operation.
in_valid  in  1  operation presented.
in_ready  out  1  unit can accept; combinational, high only in IDLE.
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
src1  in  XLEN  rs1 value (multiplicand/dividend).
src2  in  XLEN  rs2 value (multiplier/divisor).
rd_addr_i  in  REG_ADDR_W  destination register.
rd_enable_i  in  1  writeback requested.
out_valid  out  1  result available.
out_ready  in  1  downstream consumes result.
rd_data_o  out  XLEN  result.
rd_addr_o  out  REG_ADDR_W  captured destination.
rd_enable_o  out  1  out_valid & captured rd_enable & (captured rd_addr != 0).
busy  out  1  state != IDLE.

Behaviour:
Reset and priority:
- On rst: state IDLE; out_valid, rd_data_o, rd_addr_o, rd_enable_o and busy are 0; in_ready is 1.
- Priority order: rst, then flush, then normal operation.

States:
- IDLE -> CALC on accept (in_valid & in_ready & !flush), for normal operations.
- IDLE -> DONE directly on accept, for special-case divides.
- CALC -> DONE on the edge of the final iteration.
- DONE -> IDLE on out_ready.
- Any state -> IDLE on flush. out_valid is 0 the following cycle. The dropped result never asserts rd_enable_o.

Accept edge:
- Capture op, rd_addr_i and rd_enable_i.
- Capture operand magnitudes: |x| for signed sources, where MULH takes both signed, MULHSU takes src1 signed only, DIV/REM take both signed.
- Record the result sign.
- Load the iteration counter with XLEN.

Multiply (MUL, MULH, MULHSU, MULHU):
- Radix-2 shift-add, one bit per CALC cycle, 2*XLEN-bit accumulator.
- Two's-complement negate the product if the sign is negative.
- MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.

Divide (DIV, DIVU, REM, REMU):
- Restoring division, one quotient bit per CALC cycle.
- Quotient sign = sign(src1) XOR sign(src2). Remainder sign = sign(src1).

Latency and timing:
- Normal operations: out_valid is high from XLEN cycles after the accept edge.
- Special cases: out_valid is high the cycle after accept.
- Sign fixup and result selection are registered into rd_data_o on the final CALC edge. No extra cycle is added.

Special cases (resolved at accept, no CALC):
- Divide by zero (src2 == 0): quotient = all ones; remainder = src1.
- Signed overflow (DIV/REM, src1 = 1 followed by XLEN-1 zeros, src2 = all ones): quotient = src1; remainder = 0.

Handshake:
- In DONE, rd_data_o, rd_addr_o and rd_enable_o are held stable while out_ready is low.
- No accept in the same cycle as the DONE->IDLE transition; the earliest next accept is the following cycle.
- in_valid while not in_ready is ignored; the operands are not captured.

Width rules:
- Operations with a MUL low half are the same signed or unsigned.
- Intermediate arithmetic is XLEN+1 bits wide, so no overflow is lost.

Test Plan:
1. MUL 7 x 0xFFFFFFFD (-3) -> rd_data_o 0xFFFFFFEB; out_valid exactly 32 cycles after accept. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
2. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV -7/2 -> 0xFFFFFFFD; REM -7%2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100%7 -> 2.
4. DIVU 5/0 -> 0xFFFFFFFF, REM 5%0 -> 5, both out_valid 1 cycle after accept. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
5. Hold out_ready low 10 cycles after DONE -> outputs stable and in_ready low; out_ready high -> IDLE next cycle. An op with rd_addr_i 0 -> rd_enable_o stays 0.
6. flush at CALC cycle 10 -> no out_valid; the next op issued 2 cycles later gives the correct result. rst mid-CALC -> all outputs 0 and in_ready 1 next cycle.
